// File: rtl/spi_master_tx_engine.sv
// SPI master transmit engine: pops 32-bit words from the TX FIFO and shifts them out MSB-first.
// Quad (4-bit) mode is compiled in only when SPI_TX_QUAD_EN is defined; otherwise standard mode only.
module spi_master_tx_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic                  tx_edge_i,
    input  logic                  en_quad_i,
    input  logic [CNT_WIDTH-1:0]  counter_in_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  data_valid_i,
    output logic                  data_ready_o,
    output logic                  sdo0_o,
    output logic                  sdo1_o,
    output logic                  sdo2_o,
    output logic                  sdo3_o,
    output logic                  clk_en_o,
    output logic                  tx_done_o
);

    typedef enum logic [1:0] {IDLE, TRANSMIT, WAIT_DATA} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, shift_next;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [CNT_WIDTH-1:0]  target_q, target_d, start_target;
    logic                  done_q, done_d;
    logic                  load, accept, word_boundary;
    logic [3:0]            sdo_bus;

    assign cnt_inc = cnt_q + CNT_WIDTH'(1);

`ifdef SPI_TX_QUAD_EN
    logic quad_q;

    assign start_target  = en_quad_i ? (counter_in_i >> 2) : counter_in_i;
    assign word_boundary = quad_q ? (cnt_inc[2:0] == 3'd0) : (cnt_inc[4:0] == 5'd0);
    assign shift_next    = quad_q ? {shift_q[DATA_WIDTH-5:0], 4'b0000}
                                  : {shift_q[DATA_WIDTH-2:0], 1'b0};
    assign sdo_bus       = quad_q ? shift_q[DATA_WIDTH-1 -: 4] : {3'b000, shift_q[DATA_WIDTH-1]};

    // Mode is captured once per transfer, together with the target.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)     quad_q <= 1'b0;
        else if (accept) quad_q <= en_quad_i;
    end
`else
    logic unused_en_quad;

    assign unused_en_quad = en_quad_i;
    assign start_target   = counter_in_i;
    assign word_boundary  = (cnt_inc[4:0] == 5'd0);
    assign shift_next     = {shift_q[DATA_WIDTH-2:0], 1'b0};
    assign sdo_bus        = {3'b000, shift_q[DATA_WIDTH-1]};
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            target_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        done_d   = 1'b0;
        load     = 1'b0;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_i) begin
                    if (start_target == '0) begin
                        done_d = 1'b1;
                    end else begin
                        accept   = 1'b1;
                        target_d = start_target;
                        cnt_d    = '0;
                        if (data_valid_i) begin
                            load    = 1'b1;
                            shift_d = data_i;
                            state_d = TRANSMIT;
                        end else begin
                            state_d = WAIT_DATA;
                        end
                    end
                end
            end
            TRANSMIT: begin
                if (tx_edge_i) begin
                    cnt_d   = cnt_inc;
                    shift_d = shift_next;
                    if (cnt_inc == target_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (word_boundary) begin
                        // A word boundary reloads from the FIFO, or parks the SPI clock on underrun.
                        if (data_valid_i) begin
                            load    = 1'b1;
                            shift_d = data_i;
                        end else begin
                            state_d = WAIT_DATA;
                        end
                    end
                end
            end
            WAIT_DATA: begin
                if (data_valid_i) begin
                    load    = 1'b1;
                    shift_d = data_i;
                    state_d = TRANSMIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_ready_o = load;
        clk_en_o     = (state_q == TRANSMIT);
        tx_done_o    = done_q;
        sdo0_o       = sdo_bus[0];
        sdo1_o       = sdo_bus[1];
        sdo2_o       = sdo_bus[2];
        sdo3_o       = sdo_bus[3];
    end

endmodule

// File: tb/tb_spi_master_tx_engine.sv
// Scoreboard bench for spi_master_tx_engine: a FIFO model, a clock-generator edge model,
// and a monitor comparing each shifted bit/nibble and tx_done against a reference stream.
module tb_spi_master_tx_engine;

    localparam int CW = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          en_i;
    logic          tx_edge_i;
    logic          en_quad_i;
    logic [CW-1:0] counter_in_i;
    logic [31:0]   data_i;
    logic          data_valid_i;
    logic          data_ready_o;
    logic          sdo0_o, sdo1_o, sdo2_o, sdo3_o;
    logic          clk_en_o;
    logic          tx_done_o;

    spi_master_tx_engine #(.DATA_WIDTH(32), .CNT_WIDTH(CW)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .en_i         (en_i),
        .tx_edge_i    (tx_edge_i),
        .en_quad_i    (en_quad_i),
        .counter_in_i (counter_in_i),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
        .data_ready_o (data_ready_o),
        .sdo0_o       (sdo0_o),
        .sdo1_o       (sdo1_o),
        .sdo2_o       (sdo2_o),
        .sdo3_o       (sdo3_o),
        .clk_en_o     (clk_en_o),
        .tx_done_o    (tx_done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [3:0] nib; bit last; } exp_t;
    typedef struct { int delay; logic [31:0] word; } feed_t;

    int          compared   = 0;
    int          mismatched = 0;
    exp_t        exp_q[$];
    bit          start_zero_q[$];
    logic [31:0] fifo_q[$];
    feed_t       feed_q[$];
    logic [31:0] stim_words[$];
    int          stim_delays[$];
    int          pops       = 0;
    int          edges_seen = 0;
    int          done_seen  = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic failNow(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s at %0t", name, $time);
    endtask

    // FIFO model: pops on a sampled data_ready_o, and a feeder that pushes words after set delays.
    initial begin : fifo_model
        bit pop_now;
        int feed_cnt;
        feed_cnt     = 0;
        data_valid_i = 1'b0;
        data_i       = '0;
        forever begin
            @(negedge clk_i);
            pop_now = data_ready_o;
            if (data_ready_o) checkOutput("pop_only_when_valid", {31'd0, data_valid_i}, 32'd1);
            @(posedge clk_i);
            #1;
            if (pop_now && fifo_q.size() > 0) begin
                void'(fifo_q.pop_front());
                pops++;
            end
            if (feed_q.size() == 0) begin
                feed_cnt = 0;
            end else if (feed_cnt >= feed_q[0].delay) begin
                fifo_q.push_back(feed_q[0].word);
                void'(feed_q.pop_front());
                feed_cnt = 0;
            end else begin
                feed_cnt++;
            end
            data_valid_i = (fifo_q.size() > 0);
            data_i       = (fifo_q.size() > 0) ? fifo_q[0] : $urandom;
        end
    end

    // SPI clock generator model: edges only while clk_en_o, plus stray edges otherwise.
    initial begin : edge_gen
        int gap;
        gap       = 0;
        tx_edge_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (clk_en_o) begin
                if (gap > 0) begin
                    gap--;
                    tx_edge_i = 1'b0;
                end else begin
                    tx_edge_i = 1'b1;
                    gap = $urandom_range(0, 2);
                end
            end else begin
                tx_edge_i = ($urandom_range(0, 3) == 0);
            end
        end
    end

    // Monitor: every live edge consumes one expected bit/nibble; done must follow the last one.
    initial begin : monitor
        bit   done_due;
        exp_t e;
        done_due = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                done_due = 1'b0;
            end else begin
                if (done_due) begin
                    checkOutput("tx_done_pulse", {31'd0, tx_done_o}, 32'd1);
                    checkOutput("clk_en_at_done", {31'd0, clk_en_o}, 32'd0);
                    done_due = 1'b0;
                end else begin
                    checkOutput("tx_done_quiet", {31'd0, tx_done_o}, 32'd0);
                end
                if (tx_done_o) done_seen++;
                if (tx_edge_i && clk_en_o) begin
                    if (exp_q.size() == 0) begin
                        failNow("edge_without_expected_data");
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("sdo", {28'd0, sdo3_o, sdo2_o, sdo1_o, sdo0_o}, {28'd0, e.nib});
                        edges_seen++;
                        if (e.last) done_due = 1'b1;
                    end
                end
                if (en_i && start_zero_q.size() > 0) begin
                    if (start_zero_q.pop_front()) done_due = 1'b1;
                end
            end
        end
    end

    task automatic doReset();
        rst_ni = 1'b0;
        exp_q.delete();
        start_zero_q.delete();
        feed_q.delete();
        fifo_q.delete();
        repeat (3) @(posedge clk_i);
        #3 rst_ni = 1'b1;
        repeat (2) @(posedge clk_i);
    endtask

    // One transfer: builds the reference stream from the words, feeds the FIFO, pulses en_i.
    task automatic applyStimulus(input int counter, input bit quad, input int reset_after);
        bit          q;
        int          t, epw, nwords, done_before, edge_base, k;
        bit          valid_at;
        logic [31:0] w;
        exp_t        e;
        feed_t       f;
`ifdef SPI_TX_QUAD_EN
        q = quad;
`else
        q = 1'b0;
`endif
        t      = q ? (counter / 4) : counter;
        epw    = q ? 8 : 32;
        nwords = (t + epw - 1) / epw;
        while (stim_words.size() < nwords) stim_words.push_back($urandom);
        while (stim_delays.size() < nwords)
            stim_delays.push_back(($urandom_range(0, 4) == 0) ? $urandom_range(5, 40) : $urandom_range(0, 1));
        for (int i = 0; i < t; i++) begin
            w = stim_words[i / epw];
            k = i % epw;
            e.nib  = q ? w[31 - 4*k -: 4] : {3'b000, w[31 - k]};
            e.last = (i == t - 1);
            exp_q.push_back(e);
        end
        for (int i = 0; i < nwords; i++) begin
            f.delay = stim_delays[i];
            f.word  = stim_words[i];
            feed_q.push_back(f);
        end
        start_zero_q.push_back(t == 0);
        pops        = 0;
        done_before = done_seen;
        edge_base   = edges_seen;
        @(posedge clk_i);
        #1;
        counter_in_i = CW'(counter);
        en_quad_i    = quad;
        en_i         = 1'b1;
        @(negedge clk_i);
        valid_at = data_valid_i;
        @(posedge clk_i);
        #1;
        en_i         = 1'b0;
        counter_in_i = CW'($urandom);
        en_quad_i    = $urandom_range(0, 1);
        @(negedge clk_i);
        checkOutput("clk_en_latency", {31'd0, clk_en_o}, {31'd0, (valid_at && t != 0)});
        if (reset_after > 0) begin
            for (int c = 0; c < 2000 && edges_seen < edge_base + reset_after; c++) @(negedge clk_i);
            @(posedge clk_i);
            #2 rst_ni = 1'b0;
            #1;
            checkOutput("outputs_in_reset",
                {25'd0, data_ready_o, clk_en_o, tx_done_o, sdo3_o, sdo2_o, sdo1_o, sdo0_o}, 32'd0);
            exp_q.delete();
            start_zero_q.delete();
            repeat (3) @(posedge clk_i);
            #3 rst_ni = 1'b1;
            repeat (3) @(negedge clk_i);
            checkOutput("pops_after_reset", pops, 1);
            checkOutput("no_done_after_reset", done_seen, done_before);
        end else begin
            for (int c = 0; c < 4000 && done_seen == done_before; c++) @(negedge clk_i);
            if (done_seen == done_before) begin
                failNow("done_timeout");
                doReset();
            end else begin
                checkOutput("pop_count", pops, nwords);
                checkOutput("bits_left", exp_q.size(), 0);
            end
        end
        feed_q.delete();
        fifo_q.delete();
        stim_words.delete();
        stim_delays.delete();
        repeat ($urandom_range(1, 4)) @(posedge clk_i);
    endtask

    initial begin
        rst_ni       = 1'b0;
        en_i         = 1'b0;
        en_quad_i    = 1'b0;
        counter_in_i = '0;
        repeat (3) @(posedge clk_i);
        #3 rst_ni = 1'b1;
        @(negedge clk_i);
        checkOutput("reset_outputs",
            {25'd0, data_ready_o, clk_en_o, tx_done_o, sdo3_o, sdo2_o, sdo1_o, sdo0_o}, 32'd0);

        $display("[TB] standard 32 bits");
        stim_words.push_back(32'hA5A5_0F0F); stim_delays.push_back(0);
        applyStimulus(32, 1'b0, 0);

        $display("[TB] quad 64 bits");
        stim_words.push_back(32'h1234_5678); stim_delays.push_back(0);
        stim_words.push_back(32'h9ABC_DEF0); stim_delays.push_back(0);
        applyStimulus(64, 1'b1, 0);

        $display("[TB] underrun, second word late");
        stim_words.push_back(32'hDEAD_BEEF); stim_delays.push_back(0);
        stim_words.push_back(32'h1357_9BDF); stim_delays.push_back(110);
        applyStimulus(64, 1'b0, 0);

        $display("[TB] partial word, 12 bits");
        stim_words.push_back(32'hFFF0_0000); stim_delays.push_back(0);
        applyStimulus(12, 1'b0, 0);

        $display("[TB] zero-length transfer");
        applyStimulus(0, 1'b0, 0);

        $display("[TB] reset after edge 5");
        stim_words.push_back(32'hC3C3_5A5A); stim_delays.push_back(0);
        applyStimulus(32, 1'b0, 5);
        stim_words.push_back(32'h8001_7FFE); stim_delays.push_back(0);
        applyStimulus(32, 1'b0, 0);

        $display("[TB] randomized transfers");
        for (int n = 0; n < 30; n++) begin
            applyStimulus(($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : $urandom_range(1, 160),
                          $urandom_range(0, 1), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
